// File: rtl/demux_buf.sv
// demux_buf: routes one input stream into two independent 2-entry FIFO channels.
// Optional per-channel accept counters are built when DEMUX_BUF_CNT_EN is defined.
module demux_buf #(
    parameter int width = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] In,
    input  logic             Sel,
    input  logic             InValid,
    output logic             InReady,
    output logic [width-1:0] Out1,
    output logic [width-1:0] Out2,
    output logic             Valid1,
    output logic             Valid2,
    input  logic             Ready1,
    input  logic             Ready2,
    output logic [15:0]      Cnt1,
    output logic [15:0]      Cnt2
);

    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            room;
    logic [1:0]            valid;
    logic [1:0]            ready;
    logic [1:0][width-1:0] head;
    logic [1:0][15:0]      acc;

    assign ready   = {Ready2, Ready1};
    // Backpressure looks only at the selected channel's occupancy, never at its consumer.
    assign InReady = Sel ? room[1] : room[0];

    assign Out1   = head[0];
    assign Out2   = head[1];
    assign Valid1 = valid[0];
    assign Valid2 = valid[1];
    assign Cnt1   = acc[0];
    assign Cnt2   = acc[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [width-1:0] mem [2];
        logic             wp;
        logic             rp;
        logic [1:0]       cnt;
        logic [15:0]      acc_q;

        assign room[c]  = (cnt != 2'(DEPTH));
        assign valid[c] = (cnt != 2'd0);
        assign head[c]  = mem[rp];
        assign push[c]  = InValid && InReady && (Sel == 1'(c));
        assign pop[c]   = valid[c] && ready[c];
        assign acc[c]   = acc_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                // NOTE: storage is cleared too so the heads read 0 after reset, not stale data.
                mem[0] <= '0;
                mem[1] <= '0;
                wp     <= 1'b0;
                rp     <= 1'b0;
                cnt    <= 2'd0;
            end else begin
                if (push[c]) begin
                    mem[wp] <= In;
                    wp      <= ~wp;
                end
                if (pop[c]) begin
                    rp <= ~rp;
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt <= cnt + 2'd1;
                    2'b01:   cnt <= cnt - 2'd1;
                    default: cnt <= cnt;
                endcase
            end
        end

`ifdef DEMUX_BUF_CNT_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
            end else if (push[c]) begin
                acc_q <= acc_q + 16'd1;
            end
        end
`else
        assign acc_q = '0;
`endif
    end

endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: table-driven directed checks for demux_buf plus hand-written
// reset and counter sequences (counter expectation follows DEMUX_BUF_CNT_EN).
module tb_demux_buf;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out1;
    logic [W-1:0] out2;
    logic         valid1;
    logic         valid2;
    logic         ready1;
    logic         ready2;
    logic [15:0]  cnt1;
    logic [15:0]  cnt2;

    always #5 clk = ~clk;

    demux_buf #(.width(W), .DEPTH(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .In      (din),
        .Sel     (sel),
        .InValid (in_valid),
        .InReady (in_ready),
        .Out1    (out1),
        .Out2    (out2),
        .Valid1  (valid1),
        .Valid2  (valid2),
        .Ready1  (ready1),
        .Ready2  (ready2),
        .Cnt1    (cnt1),
        .Cnt2    (cnt2)
    );

    typedef struct {
        logic         rst;
        logic [W-1:0] din;
        logic         sel;
        logic         iv;
        logic         r1;
        logic         r2;
        logic         rdy;
        logic         v1;
        logic [W-1:0] o1;
        logic         v2;
        logic [W-1:0] o2;
    } vec_t;

    vec_t vecs [18];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //              rst  din           sel   iv    r1    r2    rdy   v1    o1            v2    o2
        vecs[0]  = '{1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h1,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,         1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h2,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,         1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h3,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,         1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'hBB,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,         1'b1, 32'hBB};
        vecs[7]  = '{1'b0, 32'h3,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,         1'b1, 32'hBB};
        vecs[8]  = '{1'b0, 32'h3,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3,         1'b1, 32'hBB};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2,         1'b1, 32'hBB};
        vecs[10] = '{1'b0, 32'h7,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2,         1'b1, 32'h7};
        vecs[11] = '{1'b0, 32'h11,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b1, 32'h7};
        vecs[12] = '{1'b0, 32'h12,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b1, 32'h7};
        vecs[13] = '{1'b0, 32'h21,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b1, 32'h7};
        vecs[14] = '{1'b0, 32'h22,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,        1'b1, 32'h7};
        vecs[15] = '{1'b1, 32'h99,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[16] = '{1'b1, 32'h55,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};

        reset    = 1'b1;
        din      = '0;
        sel      = 1'b0;
        in_valid = 1'b0;
        ready1   = 1'b0;
        ready2   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'h1);
        check("reset valid1",   64'(valid1),   64'h0);
        check("reset valid2",   64'(valid2),   64'h0);
        check("reset out1",     64'(out1),     64'h0);
        check("reset out2",     64'(out2),     64'h0);
        check("reset cnt1",     64'(cnt1),     64'h0);
        check("reset cnt2",     64'(cnt2),     64'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            reset    = vecs[i].rst;
            din      = vecs[i].din;
            sel      = vecs[i].sel;
            in_valid = vecs[i].iv;
            ready1   = vecs[i].r1;
            ready2   = vecs[i].r2;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid1", i), 64'(valid1), 64'(vecs[i].v1));
            check($sformatf("v%0d out1", i),   64'(out1),   64'(vecs[i].o1));
            check($sformatf("v%0d valid2", i), 64'(valid2), 64'(vecs[i].v2));
            check($sformatf("v%0d out2", i),   64'(out2),   64'(vecs[i].o2));
        end

        // Counter: five accepts into channel 2, drained as they arrive so it never fills.
        reset = 1'b0;
        sel   = 1'b1;
        ready1 = 1'b0;
        ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din      = 32'(i + 'h40);
            in_valid = 1'b1;
            #1;
            check($sformatf("cnt push%0d in_ready", i), 64'(in_ready), 64'h1);
            @(posedge clk);
            #1;
            check($sformatf("cnt push%0d out2", i), 64'(out2), 64'(i + 'h40));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cnt drained valid2", 64'(valid2), 64'h0);
`ifdef DEMUX_BUF_CNT_EN
        check("cnt2 after 5", 64'(cnt2), 64'h5);
`else
        check("cnt2 after 5", 64'(cnt2), 64'h0);
`endif
        check("cnt1 after 5", 64'(cnt1), 64'h0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("cnt2 cleared", 64'(cnt2), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
